// File: rtl/string_lights_pkg.sv
// Shared types and constants for the string-lights serial link.
package string_lights_pkg;
  typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;
  localparam int LIGHTS_WIDTH = 10;
endpackage

// File: rtl/string_lights_if.sv
// Parallel load request and serial link outputs of the string-lights transmitter.
interface string_lights_if #(parameter int WIDTH = string_lights_pkg::LIGHTS_WIDTH);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic             ser_out;
  logic             ser_strobe;
  logic             busy;
  logic             done;

  modport master (output start, pattern, input ser_out, ser_strobe, busy, done);
  modport slave  (input start, pattern, output ser_out, ser_strobe, busy, done);
endinterface

// File: rtl/string_lights_tx_rate_tick.sv
// Bit-period divider: tick marks the last clk cycle of each DIV-cycle bit slot.
module rate_tick
  import string_lights_pkg::*;
#(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Restart on tick so the counter never runs past DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             div_cnt <= '0;
    else if (clear || tick) div_cnt <= '0;
    else                    div_cnt <= div_cnt + CW'(1);
  end

  assign tick = (div_cnt == LAST);
endmodule

// File: rtl/string_lights_tx.sv
// Parallel-in, serial-out transmitter for the lights chain, LSB first with a shift strobe per bit.
module string_lights_tx
  import string_lights_pkg::*;
#(
  parameter int WIDTH = LIGHTS_WIDTH,
  parameter int DIV   = 25_000_000
) (
  input  logic            clk,
  input  logic            reset,
  string_lights_if.slave  bus
);
  localparam int BW = $clog2(WIDTH);

  tx_state_t        state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             tick, clear, last_bit, accept, shift;

  rate_tick #(.DIV(DIV)) u_rate (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  assign clear    = (state != SEND);
  assign last_bit = (bit_cnt == BW'(WIDTH - 1));
  assign accept   = (state == IDLE) && bus.start;
  assign shift    = (state == SEND) && tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)         state_nxt = SEND;
      SEND:    if (tick && last_bit)  state_nxt = DONE;
      DONE:                           state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // bit_cnt parks on the last index instead of wrapping; the next accept reloads it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= bus.pattern;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg <= shreg >> 1;
      if (!last_bit) bit_cnt <= bit_cnt + BW'(1);
    end
  end

  assign bus.ser_out    = (state == SEND) && shreg[0];
  assign bus.ser_strobe = shift;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
endmodule

// File: tb/tb_string_lights_tx.sv
// Directed bench: WIDTH=10 transmitter at DIV=4 and DIV=1, with a shift-right receiver model.
module tb_string_lights_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  string_lights_if #(.WIDTH(10)) a ();
  string_lights_if #(.WIDTH(10)) b ();

  string_lights_tx #(.WIDTH(10), .DIV(4)) dut_a (.clk(clk), .reset(rst_n), .bus(a));
  string_lights_tx #(.WIDTH(10), .DIV(1)) dut_b (.clk(clk), .reset(rst_n), .bus(b));

  int total = 0;
  int fails = 0;
  int cyc = 0;
  int c0 = 0;

  logic [9:0] ledr_a, ledr_b;
  logic [9:0] bits_a, bits_b;
  int ns_a, ns_b, nd_a, nd_b;
  int st_a[$], st_b[$], dt_a[$], dt_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model plus event logs, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a.ser_strobe) begin
        ledr_a = {a.ser_out, ledr_a[9:1]};
        if (ns_a < 10) bits_a[ns_a] = a.ser_out;
        st_a.push_back(cyc - c0 + 1);
        ns_a++;
      end
      if (a.done) begin dt_a.push_back(cyc - c0 + 1); nd_a++; end
      if (b.ser_strobe) begin
        ledr_b = {b.ser_out, ledr_b[9:1]};
        if (ns_b < 10) bits_b[ns_b] = b.ser_out;
        st_b.push_back(cyc - c0 + 1);
        ns_b++;
      end
      if (b.done) begin dt_b.push_back(cyc - c0 + 1); nd_b++; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    ledr_a = '0; ledr_b = '0; bits_a = '0; bits_b = '0;
    ns_a = 0; ns_b = 0; nd_a = 0; nd_b = 0;
    st_a.delete(); st_b.delete(); dt_a.delete(); dt_b.delete();
  endtask

  // Drive start for one edge (E0) and leave the bench #1 after E0, i.e. in cycle rel 1.
  task automatic go_a(input logic [9:0] pat, input bit hold);
    @(posedge clk); #1;
    a.start = 1'b1; a.pattern = pat;
    @(posedge clk); #1;
    c0 = cyc;
    if (!hold) a.start = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    a.start = 1'b0; a.pattern = '0;
    b.start = 1'b0; b.pattern = '0;
    clr_mon();

    // Reset state
    #12;
    chk("rst_ser_out", 32'(a.ser_out), 0);
    chk("rst_strobe",  32'(a.ser_strobe), 0);
    chk("rst_busy",    32'(a.busy), 0);
    chk("rst_done",    32'(a.done), 0);
    @(negedge clk); rst_n = 1'b1;
    wait_rel(2);
    chk("idle_busy", 32'(a.busy), 0);

    // 1. Basic frame
    clr_mon();
    go_a(10'b1011001110, 0);
    wait_rel(1);
    chk("t1_busy_rel1", 32'(a.busy), 1);
    chk("t1_bit0_rel1", 32'(a.ser_out), 0);
    wait_rel(40);
    chk("t1_done_rel41", 32'(a.done), 1);
    chk("t1_busy_rel41", 32'(a.busy), 1);
    wait_rel(1);
    chk("t1_done_rel42", 32'(a.done), 0);
    chk("t1_busy_rel42", 32'(a.busy), 0);
    wait_rel(3);
    chk("t1_nstrobe", 32'(ns_a), 10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("t1_strobe%0d_time", k), (k < st_a.size()) ? 32'(st_a[k]) : 32'hFFFF, 32'(4 * (k + 1)));
    chk("t1_bits", 32'(bits_a), 32'h2CE);
    chk("t1_ledr", 32'(ledr_a), 32'h2CE);
    chk("t1_ndone", 32'(nd_a), 1);
    chk("t1_done_time", (dt_a.size() > 0) ? 32'(dt_a[0]) : 32'hFFFF, 41);

    // 2. Start ignored while busy
    clr_mon();
    go_a(10'h155, 0);
    wait_rel(12);
    a.start = 1'b1; a.pattern = 10'h3FF;
    wait_rel(1);
    a.start = 1'b0;
    wait_rel(50);
    chk("t2_ledr", 32'(ledr_a), 32'h155);
    chk("t2_nstrobe", 32'(ns_a), 10);
    chk("t2_ndone", 32'(nd_a), 1);
    chk("t2_idle", 32'(a.busy), 0);

    // 3. Pattern change after accept
    clr_mon();
    go_a(10'h2AA, 0);
    a.pattern = 10'h000;
    wait_rel(45);
    chk("t3_ledr", 32'(ledr_a), 32'h2AA);
    chk("t3_ndone", 32'(nd_a), 1);

    // 4. Async reset mid-frame
    clr_mon();
    go_a(10'h3FF, 0);
    wait_rel(17);
    chk("t4_pre_ser_out", 32'(a.ser_out), 1);
    rst_n = 1'b0;
    #1;
    chk("t4_ser_out", 32'(a.ser_out), 0);
    chk("t4_busy",    32'(a.busy), 0);
    chk("t4_strobe",  32'(a.ser_strobe), 0);
    chk("t4_done",    32'(a.done), 0);
    wait_rel(3);
    rst_n = 1'b1;
    wait_rel(30);
    chk("t4_no_done", 32'(nd_a), 0);
    clr_mon();
    go_a(10'h001, 0);
    wait_rel(45);
    chk("t4_ledr", 32'(ledr_a), 32'h001);
    chk("t4_ndone", 32'(nd_a), 1);

    // 5. Start held high: back-to-back frames
    clr_mon();
    go_a(10'h3C3, 1);
    wait_rel(100);
    a.start = 1'b0;
    wait_rel(35);
    chk("t5_ndone", 32'(nd_a), 3);
    chk("t5_nstrobe", 32'(ns_a), 30);
    for (int f = 0; f < 3; f++)
      chk($sformatf("t5_done%0d_time", f), (f < dt_a.size()) ? 32'(dt_a[f]) : 32'hFFFF, 32'(41 + 42 * f));
    chk("t5_f2_first_strobe", (st_a.size() > 10) ? 32'(st_a[10]) : 32'hFFFF, 46);
    chk("t5_ledr", 32'(ledr_a), 32'h3C3);

    // 6. DIV=1 build
    clr_mon();
    @(posedge clk); #1;
    b.start = 1'b1; b.pattern = 10'h201;
    @(posedge clk); #1;
    c0 = cyc;
    b.start = 1'b0;
    wait_rel(15);
    chk("t6_nstrobe", 32'(ns_b), 10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("t6_strobe%0d_time", k), (k < st_b.size()) ? 32'(st_b[k]) : 32'hFFFF, 32'(k + 1));
    chk("t6_bits", 32'(bits_b), 32'h201);
    chk("t6_ledr", 32'(ledr_b), 32'h201);
    chk("t6_done_time", (dt_b.size() > 0) ? 32'(dt_b[0]) : 32'hFFFF, 11);
    chk("t6_a_quiet", 32'(ns_a), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
